// File: rtl/gate_stim_pkg.sv
// Shared types and constants for the gate stimulus/response checker.
package gate_stim_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } stim_state_e;

  localparam logic [7:0] LFSR_SEED = 8'h01;
  // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting Fibonacci register.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/gate_stim_lfsr.sv
// 8-bit Fibonacci LFSR vector source; exposes the low OutW bits of the next state.
module gate_stim_lfsr
  import gate_stim_pkg::*;
#(
  parameter int unsigned OutW = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            step_i,
  output logic [OutW-1:0] next_o
);

  logic [7:0] lfsr_q, lfsr_d, lfsr_nxt;

  assign lfsr_nxt = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  assign next_o   = lfsr_nxt[OutW-1:0];

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = LFSR_SEED;
    end else if (step_i) begin
      lfsr_d = lfsr_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/gate_stim_checker.sv
// Drives an N-input OR cell with exhaustive (or, with STIM_LFSR_EN, LFSR) vectors,
// samples its output after a settle delay and counts mismatches and output toggles.
module gate_stim_checker
  import gate_stim_pkg::*;
#(
  parameter int unsigned N_IN       = 3,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] num_vec,
  output logic [N_IN-1:0]  IN,
  input  logic             Q,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] tog_cnt,
  output logic             fail
);

  localparam int unsigned SetW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  stim_state_e      state_q, state_d;
  logic [N_IN-1:0]  in_q, in_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] tog_q, tog_d;
  logic             fail_q, fail_d;
  logic             prevq_q, prevq_d;
  logic [CNT_W-1:0] vec_idx_q, vec_idx_d;
  logic [CNT_W-1:0] num_vec_q, num_vec_d;
  logic [SetW-1:0]  set_cnt_q, set_cnt_d;

  logic             accept;
  logic             last_vec;
  logic             sample_exp;
  logic [CNT_W-1:0] vec_idx_inc;
  logic [N_IN-1:0]  vec0;
  logic [N_IN-1:0]  next_vec;

  assign vec_idx_inc = vec_idx_q + CNT_W'(1);
  assign last_vec    = (vec_idx_q == num_vec_q - CNT_W'(1));
  assign sample_exp  = |in_q;

`ifdef STIM_LFSR_EN
  logic            mode_q, mode_d;
  logic            lfsr_step;
  logic [N_IN-1:0] lfsr_next;
  localparam logic [N_IN-1:0] SeedVec = LFSR_SEED[N_IN-1:0];

  assign lfsr_step = (state_q == StSample) && !last_vec;
  assign vec0      = mode_q ? SeedVec : '0;
  assign next_vec  = mode_q ? lfsr_next : vec_idx_inc[N_IN-1:0];

  // vec0 must follow the mode being captured, not the previous run's mode.
  logic [N_IN-1:0] vec0_start;
  assign vec0_start = mode ? SeedVec : '0;

  gate_stim_lfsr #(
    .OutW (N_IN)
  ) u_lfsr (
    .clk_i  (CLK),
    .rst_ni (RSTB),
    .load_i (accept),
    .step_i (lfsr_step),
    .next_o (lfsr_next)
  );

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      mode_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (accept) begin
      mode_d = mode;
    end
  end
`else
  logic            unused_mode;
  logic [N_IN-1:0] vec0_start;
  assign unused_mode = mode;
  assign vec0        = '0;
  assign vec0_start  = vec0;
  assign next_vec    = vec_idx_inc[N_IN-1:0];
`endif

  always_comb begin
    state_d   = state_q;
    in_d      = in_q;
    err_d     = err_q;
    tog_d     = tog_q;
    fail_d    = (err_q != '0);
    prevq_d   = prevq_q;
    vec_idx_d = vec_idx_q;
    num_vec_d = num_vec_q;
    set_cnt_d = set_cnt_q;
    accept    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept    = 1'b1;
          err_d     = '0;
          tog_d     = '0;
          fail_d    = 1'b0;
          prevq_d   = 1'b0;
          vec_idx_d = '0;
          set_cnt_d = '0;
          num_vec_d = num_vec;
          if (num_vec != '0) begin
            in_d    = vec0_start;
            state_d = StSettle;
          end else begin
            state_d = StDone;
          end
        end
      end
      StSettle: begin
        if (set_cnt_q == SetW'(SETTLE_CYC - 1)) begin
          set_cnt_d = '0;
          state_d   = StSample;
        end else begin
          set_cnt_d = set_cnt_q + SetW'(1);
        end
      end
      StSample: begin
        if (Q != sample_exp && err_q != '1) begin
          err_d = err_q + CNT_W'(1);
        end
        if (Q != prevq_q) begin
          prevq_d = Q;
          if (tog_q != '1) begin
            tog_d = tog_q + CNT_W'(1);
          end
        end
        if (last_vec) begin
          state_d = StDone;
        end else begin
          vec_idx_d = vec_idx_inc;
          in_d      = next_vec;
          state_d   = StSettle;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q   <= StIdle;
      in_q      <= '0;
      err_q     <= '0;
      tog_q     <= '0;
      fail_q    <= 1'b0;
      prevq_q   <= 1'b0;
      vec_idx_q <= '0;
      num_vec_q <= '0;
      set_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      in_q      <= in_d;
      err_q     <= err_d;
      tog_q     <= tog_d;
      fail_q    <= fail_d;
      prevq_q   <= prevq_d;
      vec_idx_q <= vec_idx_d;
      num_vec_q <= num_vec_d;
      set_cnt_q <= set_cnt_d;
    end
  end

  assign IN      = in_q;
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign err_cnt = err_q;
  assign tog_cnt = tog_q;
  assign fail    = fail_q;

endmodule

// File: tb/tb_gate_stim_checker.sv
// Directed bench for gate_stim_checker with a behavioural OR3 (or tied-low) cell model.
module tb_gate_stim_checker;

  logic        clk = 1'b0;
  logic        rstb;
  logic        start;
  logic        mode;
  logic [15:0] num_vec;
  logic [2:0]  in_w;
  logic        q;
  logic        busy;
  logic        done;
  logic [15:0] err_cnt;
  logic [15:0] tog_cnt;
  logic        fail;
  logic        q_tie0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] in_log [0:63];
  int done_at;
  int fail_at;
  int busy_cnt;
  logic done_after;
  logic busy_after;

  always #5 clk = ~clk;

  assign q = q_tie0 ? 1'b0 : |in_w;

  gate_stim_checker #(
    .N_IN       (3),
    .SETTLE_CYC (2),
    .CNT_W      (16)
  ) dut (
    .CLK     (clk),
    .RSTB    (rstb),
    .start   (start),
    .mode    (mode),
    .num_vec (num_vec),
    .IN      (in_w),
    .Q       (q),
    .busy    (busy),
    .done    (done),
    .err_cnt (err_cnt),
    .tog_cnt (tog_cnt),
    .fail    (fail)
  );

  // Starts a run, logs IN at every vector-apply edge, and records done/fail/busy timing.
  // Inputs are scrambled after the start edge; poke also pulses start mid-run.
  task automatic run_vec(input logic [15:0] nv, input logic md, input logic poke);
    @(negedge clk);
    start   = 1'b1;
    num_vec = nv;
    mode    = md;
    @(posedge clk);
    #1;
    start    = 1'b0;
    num_vec  = 16'd5;
    mode     = ~md;
    done_at  = -1;
    fail_at  = -1;
    busy_cnt = 0;
    in_log[0] = in_w;
    if (busy) busy_cnt++;
    if (done) done_at = 0;
    for (int c = 1; c <= 400 && done_at < 0; c++) begin
      @(posedge clk);
      #1;
      if (poke && c == 4) start = 1'b1;
      if (c == 5) start = 1'b0;
      if ((c % 3) == 0 && (c / 3) < 64) in_log[c/3] = in_w;
      if (busy) busy_cnt++;
      if (fail && fail_at < 0) fail_at = c;
      if (done) done_at = c;
    end
    if (done_at < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_timeout: done never seen, required within 400 cycles");
    end
    @(posedge clk);
    #1;
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    #12;
    n_checks++;
    if (in_w !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: IN=%0d busy=%b done=%b, required 0 0 0", in_w, busy, done);
    end
    n_checks++;
    if (err_cnt !== 16'd0 || tog_cnt !== 16'd0 || fail !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cnt: err=%0d tog=%0d fail=%b, required 0 0 0", err_cnt, tog_cnt, fail);
    end
    @(negedge clk);
    rstb = 1'b1;
  endtask

  task automatic test_exhaustive();
    q_tie0 = 1'b0;
    run_vec(16'd8, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (in_log[k] !== 3'(k)) begin
        n_fail++;
        $display("FAIL exh_in[%0d]: got %0d, required %0d", k, in_log[k], k);
      end
    end
    n_checks++;
    if (done_at !== 24) begin
      n_fail++;
      $display("FAIL exh_done_at: got %0d, required 24", done_at);
    end
    n_checks++;
    if (busy_cnt !== 25 || done_after !== 1'b0 || busy_after !== 1'b0) begin
      n_fail++;
      $display("FAIL exh_busy: busy_cnt=%0d done_after=%b busy_after=%b, required 25 0 0",
               busy_cnt, done_after, busy_after);
    end
    n_checks++;
    if (err_cnt !== 16'd0 || tog_cnt !== 16'd1 || fail !== 1'b0 || in_w !== 3'd7) begin
      n_fail++;
      $display("FAIL exh_result: err=%0d tog=%0d fail=%b IN=%0d, required 0 1 0 7",
               err_cnt, tog_cnt, fail, in_w);
    end
  endtask

  task automatic test_tied_zero();
    q_tie0 = 1'b1;
    run_vec(16'd8, 1'b0, 1'b1);
    n_checks++;
    if (done_at !== 24) begin
      n_fail++;
      $display("FAIL tie0_done_at: got %0d, required 24", done_at);
    end
    n_checks++;
    if (err_cnt !== 16'd7 || tog_cnt !== 16'd0 || fail !== 1'b1) begin
      n_fail++;
      $display("FAIL tie0_result: err=%0d tog=%0d fail=%b, required 7 0 1",
               err_cnt, tog_cnt, fail);
    end
    n_checks++;
    if (fail_at !== 7) begin
      n_fail++;
      $display("FAIL tie0_fail_at: got %0d, required 7", fail_at);
    end
  endtask

  task automatic test_zero_vec();
    q_tie0 = 1'b0;
    run_vec(16'd0, 1'b0, 1'b0);
    n_checks++;
    if (done_at !== 0 || busy_cnt !== 1 || done_after !== 1'b0 || busy_after !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_timing: done_at=%0d busy_cnt=%0d done_after=%b busy_after=%b, required 0 1 0 0",
               done_at, busy_cnt, done_after, busy_after);
    end
    n_checks++;
    if (err_cnt !== 16'd0 || tog_cnt !== 16'd0 || fail !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_cnt: err=%0d tog=%0d fail=%b, required 0 0 0", err_cnt, tog_cnt, fail);
    end
  endtask

  task automatic test_wrap();
    q_tie0 = 1'b0;
    run_vec(16'd16, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (in_log[k] !== 3'(k)) begin
        n_fail++;
        $display("FAIL wrap_in[%0d]: got %0d, required %0d", k, in_log[k], k % 8);
      end
    end
    n_checks++;
    if (done_at !== 48 || err_cnt !== 16'd0 || tog_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL wrap_result: done_at=%0d err=%0d tog=%0d, required 48 0 3",
               done_at, err_cnt, tog_cnt);
    end
  endtask

  task automatic test_mid_reset();
    bit saw_done;
    q_tie0 = 1'b1;
    @(negedge clk);
    start   = 1'b1;
    num_vec = 16'd8;
    mode    = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    n_checks++;
    if (in_w !== 3'd3 || err_cnt !== 16'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: IN=%0d err=%0d busy=%b, required 3 2 1", in_w, err_cnt, busy);
    end
    #1;
    rstb = 1'b0;
    #1;
    n_checks++;
    if (in_w !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || err_cnt !== 16'd0 || fail !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: IN=%0d busy=%b done=%b err=%0d fail=%b, required 0 0 0 0 0",
               in_w, busy, done, err_cnt, fail);
    end
    @(negedge clk);
    rstb = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_quiet: done/busy seen after reset, required none");
    end
    q_tie0 = 1'b0;
    run_vec(16'd8, 1'b0, 1'b0);
    n_checks++;
    if (done_at !== 24 || err_cnt !== 16'd0 || tog_cnt !== 16'd1 || fail !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_rerun: done_at=%0d err=%0d tog=%0d fail=%b, required 24 0 1 0",
               done_at, err_cnt, tog_cnt, fail);
    end
  endtask

  task automatic test_mode();
    logic [2:0]  exp_in [0:3];
    logic [15:0] exp_tog;
`ifdef STIM_LFSR_EN
    exp_in[0] = 3'd1;
    exp_in[1] = 3'd2;
    exp_in[2] = 3'd4;
    exp_in[3] = 3'd0;
    exp_tog   = 16'd2;
`else
    exp_in[0] = 3'd0;
    exp_in[1] = 3'd1;
    exp_in[2] = 3'd2;
    exp_in[3] = 3'd3;
    exp_tog   = 16'd1;
`endif
    q_tie0 = 1'b0;
    run_vec(16'd4, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (in_log[k] !== exp_in[k]) begin
        n_fail++;
        $display("FAIL mode_in[%0d]: got %0d, required %0d", k, in_log[k], exp_in[k]);
      end
    end
    n_checks++;
    if (done_at !== 12 || err_cnt !== 16'd0 || tog_cnt !== exp_tog) begin
      n_fail++;
      $display("FAIL mode_result: done_at=%0d err=%0d tog=%0d, required 12 0 %0d",
               done_at, err_cnt, tog_cnt, exp_tog);
    end
  endtask

  initial begin
    start   = 1'b0;
    mode    = 1'b0;
    num_vec = 16'd0;
    q_tie0  = 1'b0;
    test_reset();
    test_exhaustive();
    test_tied_zero();
    test_zero_vec();
    test_wrap();
    test_mid_reset();
    test_mode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
